// File: rtl/orb_wr_arbiter_pkg.sv
// Shared constants for the orbital packer write arbiter: default widths,
// FSM encoding and channel indices.
package orb_pkg;
  localparam int ORB_AW = 11;
  localparam int ORB_DW = 12;

  typedef enum logic {ST_IDLE = 1'b0, ST_WRITE = 1'b1} state_e;

  localparam logic CH1 = 1'b0;
  localparam logic CH2 = 1'b1;
endpackage

// File: rtl/orb_wr_arbiter_if.sv
// Packer-side request pairs, page-switch input and ping-pong RAM write port.
interface orb_wr_arbiter_if import orb_pkg::*; #(
  parameter int AW = ORB_AW,
  parameter int DW = ORB_DW
);
  logic          iWE1;
  logic [AW-1:0] iAddr1;
  logic [DW-1:0] iData1;
  logic          iWE2;
  logic [AW-1:0] iAddr2;
  logic [DW-1:0] iData2;
  logic          iSW;
  logic          oWE;
  logic [AW:0]   oAddr;
  logic [DW-1:0] oData;
  logic          oPage;
  logic          oSwap;
  logic [1:0]    oOvf;
  logic          oBusy;

  modport master (
    output iWE1, iAddr1, iData1, iWE2, iAddr2, iData2, iSW,
    input  oWE, oAddr, oData, oPage, oSwap, oOvf, oBusy
  );

  modport slave (
    input  iWE1, iAddr1, iData1, iWE2, iAddr2, iData2, iSW,
    output oWE, oAddr, oData, oPage, oSwap, oOvf, oBusy
  );
endinterface

// File: rtl/orb_wr_arbiter_req_capture.sv
// One packer channel: WE rising-edge detect, word hold register, pending flag
// and sticky overflow when a second edge arrives before the first is served.
module orb_req_capture import orb_pkg::*; #(
  parameter int AW = ORB_AW,
  parameter int DW = ORB_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_data,
  input  logic          i_clr,
  input  logic          i_ovf_clr,
  output logic          o_pend,
  output logic          o_ovf,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data
);
  logic          r_we_d;
  logic          r_pend;
  logic          r_ovf;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          w_edge;
  logic          w_drop;

  assign w_edge = i_we & ~r_we_d;
  // A word still waiting (and not retiring this cycle) wins over the new one.
  assign w_drop = w_edge & r_pend & ~i_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we_d <= 1'b0;
      r_pend <= 1'b0;
      r_ovf  <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we_d <= i_we;
      r_pend <= w_edge | (r_pend & ~i_clr);
      r_ovf  <= ~i_ovf_clr & (r_ovf | w_drop);
      if (w_edge && !w_drop) begin
        r_addr <= i_addr;
        r_data <= i_data;
      end
    end
  end

  assign o_pend = r_pend;
  assign o_ovf  = r_ovf;
  assign o_addr = r_addr;
  assign o_data = r_data;
endmodule

// File: rtl/orb_wr_arbiter.sv
// Round-robin arbiter sharing one ping-pong RAM write port between two packer
// channels, with page swaps deferred until every accepted word has drained.
module orb_wr_arbiter import orb_pkg::*; #(
  parameter int AW     = ORB_AW,
  parameter int DW     = ORB_DW,
  parameter int WR_CYC = 2
) (
  input logic clk,
  input logic rst,
  orb_wr_arbiter_if.slave bus
);
  localparam logic [3:0] LP_CYC = 4'(WR_CYC);

  logic [1:0]    w_iwe;
  logic [AW-1:0] w_iaddr [2];
  logic [DW-1:0] w_idata [2];
  logic [1:0]    w_pend;
  logic [1:0]    w_ovf;
  logic [1:0]    w_clr;
  logic [AW-1:0] w_haddr [2];
  logic [DW-1:0] w_hdata [2];

  state_e        r_state, w_state_nx;
  logic          r_gnt, r_last, w_sel;
  logic [3:0]    r_cnt;
  logic          r_we, r_page, r_swap;
  logic [AW:0]   r_addr;
  logic [DW-1:0] r_data;
  logic          r_sw_s1, r_sw_s2, r_sw_old, r_swap_req;
  logic          w_swap, w_start, w_done;

  assign w_iwe      = {bus.iWE2, bus.iWE1};
  assign w_iaddr[0] = bus.iAddr1;
  assign w_iaddr[1] = bus.iAddr2;
  assign w_idata[0] = bus.iData1;
  assign w_idata[1] = bus.iData2;

  for (genvar g = 0; g < 2; g++) begin : g_ch
    orb_req_capture #(.AW(AW), .DW(DW)) u_cap (
      .clk      (clk),
      .rst      (rst),
      .i_we     (w_iwe[g]),
      .i_addr   (w_iaddr[g]),
      .i_data   (w_idata[g]),
      .i_clr    (w_clr[g]),
      .i_ovf_clr(w_swap),
      .o_pend   (w_pend[g]),
      .o_ovf    (w_ovf[g]),
      .o_addr   (w_haddr[g]),
      .o_data   (w_hdata[g])
    );
  end

  // Swap only once both channels are drained; it therefore never races a grant.
  assign w_swap  = (r_state == ST_IDLE) & ~|w_pend & r_swap_req;
  assign w_start = (r_state == ST_IDLE) & |w_pend & ~w_swap;
  assign w_done  = (r_state == ST_WRITE) & (r_cnt == LP_CYC);
  assign w_sel   = (&w_pend) ? ~r_last : (w_pend[CH1] ? CH1 : CH2);
  assign w_clr   = {2{w_done}} & (r_gnt ? 2'b10 : 2'b01);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_state_nx = ST_WRITE;
      ST_WRITE: if (w_done)  w_state_nx = ST_IDLE;
      default:  w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_gnt  <= CH1;
      r_last <= CH2;
      r_cnt  <= '0;
    end else if (w_start) begin
      r_we   <= 1'b1;
      r_addr <= {r_page, w_haddr[w_sel]};
      r_data <= w_hdata[w_sel];
      r_gnt  <= w_sel;
      r_last <= w_sel;
      r_cnt  <= 4'd1;
    end else if (r_state == ST_WRITE) begin
      if (w_done) r_we  <= 1'b0;
      else        r_cnt <= r_cnt + 4'd1;
    end
  end

  // iSW is asynchronous; every synchronized toggle latches one swap request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_s1    <= 1'b0;
      r_sw_s2    <= 1'b0;
      r_sw_old   <= 1'b0;
      r_swap_req <= 1'b0;
      r_page     <= 1'b0;
      r_swap     <= 1'b0;
    end else begin
      r_sw_s1    <= bus.iSW;
      r_sw_s2    <= r_sw_s1;
      r_sw_old   <= r_sw_s2;
      r_swap_req <= (r_sw_s2 != r_sw_old) | (r_swap_req & ~w_swap);
      r_swap     <= w_swap;
      if (w_swap) r_page <= ~r_page;
    end
  end

  assign bus.oWE   = r_we;
  assign bus.oAddr = r_addr;
  assign bus.oData = r_data;
  assign bus.oPage = r_page;
  assign bus.oSwap = r_swap;
  assign bus.oOvf  = w_ovf;
  assign bus.oBusy = (r_state == ST_WRITE);
endmodule

// File: tb/tb_orb_wr_arbiter.sv
// Directed bench for orb_wr_arbiter: u1 (WR_CYC=2) covers arbitration, overflow
// and page swaps; u2 (WR_CYC=4) covers asynchronous reset in mid-write.
module tb_orb_wr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  orb_wr_arbiter_if #(.AW(11), .DW(12)) w1 ();
  orb_wr_arbiter_if #(.AW(11), .DW(12)) w2 ();

  orb_wr_arbiter #(.AW(11), .DW(12), .WR_CYC(2)) u1 (.clk(clk), .rst(rst),  .bus(w1.slave));
  orb_wr_arbiter #(.AW(11), .DW(12), .WR_CYC(4)) u2 (.clk(clk), .rst(rst2), .bus(w2.slave));

  typedef struct {
    logic [11:0] addr;
    logic [11:0] data;
    int          start;
    int          len;
  } wr_t;

  wr_t  wq[$];
  int   swq[$];
  logic we_prev = 1'b0;
  logic [11:0] cur_a, cur_d;
  int   cur_s, cur_len;
  int   unstable = 0;

  // Log each u1 write burst (address, data, first cycle, length) and swap pulses.
  always @(negedge clk) begin
    if (w1.oWE) begin
      if (!we_prev) begin
        cur_a = w1.oAddr; cur_d = w1.oData; cur_s = cyc; cur_len = 0;
      end else if (w1.oAddr !== cur_a || w1.oData !== cur_d) begin
        unstable++;
      end
      cur_len++;
    end else if (we_prev) begin
      wq.push_back('{cur_a, cur_d, cur_s, cur_len});
    end
    we_prev = w1.oWE;
    if (w1.oSwap) swq.push_back(cyc);
  end

  function automatic wr_t get_wr(int i);
    wr_t r;
    r.addr = '0; r.data = '0; r.start = -1; r.len = 0;
    if (i < wq.size()) r = wq[i];
    return r;
  endfunction

  task automatic nclk(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    w1.iWE1 = 0; w1.iWE2 = 0; w1.iSW = 0;
    nclk(2);
    rst = 1'b0;
    nclk(1);
    wq.delete(); swq.delete();
  endtask

  task automatic test_reset;
    nclk(2);
    n_cmp++; if (w1.oWE   !== 1'b0)  begin n_bad++; $display("FAIL reset_oWE: got %h want 0", w1.oWE); end
    n_cmp++; if (w1.oAddr !== 12'h0) begin n_bad++; $display("FAIL reset_oAddr: got %h want 000", w1.oAddr); end
    n_cmp++; if (w1.oData !== 12'h0) begin n_bad++; $display("FAIL reset_oData: got %h want 000", w1.oData); end
    n_cmp++; if (w1.oPage !== 1'b0)  begin n_bad++; $display("FAIL reset_oPage: got %h want 0", w1.oPage); end
    n_cmp++; if (w1.oSwap !== 1'b0)  begin n_bad++; $display("FAIL reset_oSwap: got %h want 0", w1.oSwap); end
    n_cmp++; if (w1.oOvf  !== 2'b00) begin n_bad++; $display("FAIL reset_oOvf: got %b want 00", w1.oOvf); end
    n_cmp++; if (w1.oBusy !== 1'b0)  begin n_bad++; $display("FAIL reset_oBusy: got %h want 0", w1.oBusy); end
    rst = 1'b0;
    nclk(1);
    wq.delete(); swq.delete();
  endtask

  task automatic test_single;
    int k;
    wr_t w;
    k = cyc + 1;
    w1.iWE1 = 1; w1.iAddr1 = 11'h020; w1.iData1 = 12'h5A8;
    nclk(10);
    w = get_wr(0);
    n_cmp++; if (wq.size() !== 1)  begin n_bad++; $display("FAIL single_count: got %0d want 1", wq.size()); end
    n_cmp++; if (w.addr !== 12'h020) begin n_bad++; $display("FAIL single_addr: got %h want 020", w.addr); end
    n_cmp++; if (w.data !== 12'h5A8) begin n_bad++; $display("FAIL single_data: got %h want 5a8", w.data); end
    n_cmp++; if (w.start !== k + 1)  begin n_bad++; $display("FAIL single_start: got %0d want %0d", w.start, k + 1); end
    n_cmp++; if (w.len !== 2)        begin n_bad++; $display("FAIL single_len: got %0d want 2", w.len); end
    w1.iWE1 = 0;
    nclk(2);
  endtask

  task automatic test_simul;
    int k;
    wr_t a, b;
    do_reset();
    k = cyc + 1;
    w1.iWE1 = 1; w1.iAddr1 = 11'h004; w1.iData1 = 12'h111;
    w1.iWE2 = 1; w1.iAddr2 = 11'h005; w1.iData2 = 12'h222;
    nclk(10);
    a = get_wr(0); b = get_wr(1);
    n_cmp++; if (wq.size() !== 2)    begin n_bad++; $display("FAIL tie_count: got %0d want 2", wq.size()); end
    n_cmp++; if (a.addr !== 12'h004) begin n_bad++; $display("FAIL tie_first_addr: got %h want 004", a.addr); end
    n_cmp++; if (a.start !== k + 1)  begin n_bad++; $display("FAIL tie_first_start: got %0d want %0d", a.start, k + 1); end
    n_cmp++; if (b.addr !== 12'h005) begin n_bad++; $display("FAIL tie_second_addr: got %h want 005", b.addr); end
    n_cmp++; if (b.data !== 12'h222) begin n_bad++; $display("FAIL tie_second_data: got %h want 222", b.data); end
    n_cmp++; if (b.start !== k + 4)  begin n_bad++; $display("FAIL tie_second_start: got %0d want %0d", b.start, k + 4); end
    w1.iWE1 = 0; w1.iWE2 = 0;
    nclk(2);
    // Channel 1 served last, so the next tie goes to channel 2.
    w1.iWE1 = 1; w1.iAddr1 = 11'h010; w1.iData1 = 12'h333;
    nclk(6);
    w1.iWE1 = 0;
    nclk(2);
    wq.delete();
    w1.iWE1 = 1; w1.iAddr1 = 11'h006; w1.iData1 = 12'h444;
    w1.iWE2 = 1; w1.iAddr2 = 11'h007; w1.iData2 = 12'h555;
    nclk(10);
    a = get_wr(0); b = get_wr(1);
    n_cmp++; if (a.addr !== 12'h007) begin n_bad++; $display("FAIL tie2_first_addr: got %h want 007", a.addr); end
    n_cmp++; if (a.data !== 12'h555) begin n_bad++; $display("FAIL tie2_first_data: got %h want 555", a.data); end
    n_cmp++; if (b.addr !== 12'h006) begin n_bad++; $display("FAIL tie2_second_addr: got %h want 006", b.addr); end
    w1.iWE1 = 0; w1.iWE2 = 0;
    nclk(2);
  endtask

  task automatic test_overflow;
    wr_t b;
    do_reset();
    w1.iWE1 = 1; w1.iAddr1 = 11'h0A0; w1.iData1 = 12'h101;
    w1.iWE2 = 1; w1.iAddr2 = 11'h0B0; w1.iData2 = 12'h202;
    nclk(1);
    w1.iWE2 = 0;
    nclk(1);
    w1.iWE2 = 1; w1.iAddr2 = 11'h0B1; w1.iData2 = 12'h303;
    nclk(10);
    b = get_wr(1);
    n_cmp++; if (wq.size() !== 2)    begin n_bad++; $display("FAIL ovf_count: got %0d want 2", wq.size()); end
    n_cmp++; if (b.addr !== 12'h0B0) begin n_bad++; $display("FAIL ovf_kept_addr: got %h want 0b0", b.addr); end
    n_cmp++; if (b.data !== 12'h202) begin n_bad++; $display("FAIL ovf_kept_data: got %h want 202", b.data); end
    n_cmp++; if (w1.oOvf !== 2'b10)  begin n_bad++; $display("FAIL ovf_flag: got %b want 10", w1.oOvf); end
    w1.iWE1 = 0; w1.iWE2 = 0;
    w1.iSW = ~w1.iSW;
    nclk(8);
    n_cmp++; if (w1.oOvf !== 2'b00)  begin n_bad++; $display("FAIL ovf_clear_on_swap: got %b want 00", w1.oOvf); end
    n_cmp++; if (w1.oPage !== 1'b1)  begin n_bad++; $display("FAIL ovf_swap_page: got %h want 1", w1.oPage); end
    n_cmp++; if (swq.size() !== 1)   begin n_bad++; $display("FAIL ovf_swap_pulses: got %0d want 1", swq.size()); end
  endtask

  task automatic test_swap_drain;
    int k;
    wr_t a;
    do_reset();
    k = cyc + 1;
    w1.iWE1 = 1; w1.iAddr1 = 11'h033; w1.iData1 = 12'h0AB;
    w1.iSW = ~w1.iSW;
    nclk(10);
    a = get_wr(0);
    n_cmp++; if (wq.size() !== 1)    begin n_bad++; $display("FAIL drain_count: got %0d want 1", wq.size()); end
    n_cmp++; if (a.addr !== 12'h033) begin n_bad++; $display("FAIL drain_old_page_addr: got %h want 033", a.addr); end
    n_cmp++; if (swq.size() !== 1)   begin n_bad++; $display("FAIL drain_swap_pulses: got %0d want 1", swq.size()); end
    n_cmp++; if (swq.size() > 0 && swq[0] !== k + 4) begin n_bad++; $display("FAIL drain_swap_cycle: got %0d want %0d", swq[0], k + 4); end
    n_cmp++; if (w1.oPage !== 1'b1)  begin n_bad++; $display("FAIL drain_page: got %h want 1", w1.oPage); end
    w1.iWE1 = 0;
    nclk(2);
    wq.delete();
    w1.iWE2 = 1; w1.iAddr2 = 11'h044; w1.iData2 = 12'h0CD;
    nclk(6);
    a = get_wr(0);
    n_cmp++; if (a.addr !== 12'h844) begin n_bad++; $display("FAIL drain_new_page_addr: got %h want 844", a.addr); end
    w1.iWE2 = 0;
    nclk(2);
  endtask

  task automatic test_double_toggle;
    wr_t a, b;
    wq.delete(); swq.delete();
    w1.iWE1 = 1; w1.iAddr1 = 11'h011; w1.iData1 = 12'h001;
    w1.iWE2 = 1; w1.iAddr2 = 11'h022; w1.iData2 = 12'h002;
    w1.iSW = ~w1.iSW;
    nclk(2);
    w1.iSW = ~w1.iSW;
    nclk(12);
    a = get_wr(0); b = get_wr(1);
    n_cmp++; if (swq.size() !== 1)   begin n_bad++; $display("FAIL dbl_swap_pulses: got %0d want 1", swq.size()); end
    n_cmp++; if (w1.oPage !== 1'b0)  begin n_bad++; $display("FAIL dbl_page: got %h want 0", w1.oPage); end
    n_cmp++; if (a.addr !== 12'h811) begin n_bad++; $display("FAIL dbl_first_addr: got %h want 811", a.addr); end
    n_cmp++; if (b.addr !== 12'h822) begin n_bad++; $display("FAIL dbl_second_addr: got %h want 822", b.addr); end
    n_cmp++; if (unstable !== 0)     begin n_bad++; $display("FAIL write_stable: got %0d want 0", unstable); end
    w1.iWE1 = 0; w1.iWE2 = 0;
    nclk(2);
  endtask

  task automatic test_reset_mid;
    int hi;
    w2.iWE1 = 0; w2.iWE2 = 0; w2.iSW = 0;
    w2.iAddr1 = '0; w2.iData1 = '0; w2.iAddr2 = '0; w2.iData2 = '0;
    rst2 = 1'b1;
    nclk(2);
    rst2 = 1'b0;
    nclk(1);
    w2.iSW = 1;
    nclk(8);
    n_cmp++; if (w2.oPage !== 1'b1) begin n_bad++; $display("FAIL mid_setup_page: got %h want 1", w2.oPage); end
    w2.iWE1 = 1; w2.iAddr1 = 11'h055; w2.iData1 = 12'h0EE;
    w2.iWE2 = 1; w2.iAddr2 = 11'h066; w2.iData2 = 12'h0FF;
    nclk(1);
    w2.iWE2 = 0;
    nclk(1);
    w2.iWE2 = 1;
    nclk(1);
    n_cmp++; if (w2.oWE !== 1'b1)     begin n_bad++; $display("FAIL mid_pre_oWE: got %h want 1", w2.oWE); end
    n_cmp++; if (w2.oAddr !== 12'h855) begin n_bad++; $display("FAIL mid_pre_addr: got %h want 855", w2.oAddr); end
    n_cmp++; if (w2.oOvf !== 2'b10)   begin n_bad++; $display("FAIL mid_pre_ovf: got %b want 10", w2.oOvf); end
    rst2 = 1'b1;
    #1;
    n_cmp++; if (w2.oWE !== 1'b0)   begin n_bad++; $display("FAIL mid_async_oWE: got %h want 0", w2.oWE); end
    n_cmp++; if (w2.oBusy !== 1'b0) begin n_bad++; $display("FAIL mid_async_busy: got %h want 0", w2.oBusy); end
    n_cmp++; if (w2.oPage !== 1'b0) begin n_bad++; $display("FAIL mid_async_page: got %h want 0", w2.oPage); end
    n_cmp++; if (w2.oOvf !== 2'b00) begin n_bad++; $display("FAIL mid_async_ovf: got %b want 00", w2.oOvf); end
    w2.iWE1 = 0; w2.iWE2 = 0; w2.iSW = 0;
    nclk(2);
    rst2 = 1'b0;
    nclk(1);
    w2.iWE1 = 1; w2.iAddr1 = 11'h077; w2.iData1 = 12'h0AA;
    nclk(2);
    n_cmp++; if (w2.oWE !== 1'b1)      begin n_bad++; $display("FAIL post_oWE: got %h want 1", w2.oWE); end
    n_cmp++; if (w2.oAddr !== 12'h077) begin n_bad++; $display("FAIL post_addr: got %h want 077", w2.oAddr); end
    n_cmp++; if (w2.oData !== 12'h0AA) begin n_bad++; $display("FAIL post_data: got %h want 0aa", w2.oData); end
    nclk(4);
    n_cmp++; if (w2.oWE !== 1'b0)      begin n_bad++; $display("FAIL post_oWE_end: got %h want 0", w2.oWE); end
    hi = 0;
    repeat (6) begin
      nclk(1);
      if (w2.oWE) hi++;
    end
    n_cmp++; if (hi !== 0) begin n_bad++; $display("FAIL post_lost_pend: got %0d high cycles want 0", hi); end
    w2.iWE1 = 0;
    nclk(2);
  endtask

  initial begin
    w1.iWE1 = 0; w1.iAddr1 = '0; w1.iData1 = '0;
    w1.iWE2 = 0; w1.iAddr2 = '0; w1.iData2 = '0;
    w1.iSW  = 0;
    w2.iWE1 = 0; w2.iAddr1 = '0; w2.iData1 = '0;
    w2.iWE2 = 0; w2.iAddr2 = '0; w2.iData2 = '0;
    w2.iSW  = 0;
    test_reset();
    test_single();
    test_simul();
    test_overflow();
    test_swap_drain();
    test_double_toggle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/orb_wr_arbiter.md
Name: orb_wr_arbiter

Overview:
- Shares one RAM write port between the two orbital packer channels (word/WE/address pairs 1 and 2).
- Captures each channel's write request on the rising edge of its WE and arbitrates round-robin.
- Issues a fixed-width write to a double-buffered (ping-pong) RAM; the page bit is prefixed to the address.
- Sequences page swaps requested by the SW toggle so that no accepted word lands in the wrong page.

Parameters:
AW, 11, packer address width per page
DW, 12, orbital word width
WR_CYC, 2, cycles oWE is held high per granted write (1..15)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
iWE1  in  1  channel 1 write enable (level, held for many cycles)
iAddr1  in  AW  channel 1 address
iData1  in  DW  channel 1 word
iWE2  in  1  channel 2 write enable
iAddr2  in  AW  channel 2 address
iData2  in  DW  channel 2 word
iSW  in  1  asynchronous page-switch level; each toggle requests a swap
oWE  out  1  RAM write enable
oAddr  out  AW+1  RAM address, {page, addr}
oData  out  DW  RAM write data
oPage  out  1  current write page
oSwap  out  1  one-cycle pulse when the page flips
oOvf  out  2  sticky per-channel overflow, bit0 = channel 1
oBusy  out  1  high while FSM is in WRITE

Behaviour:
- Reset (async, rst=1): all outputs 0; pending flags, hold registers, the iWE delay flops, the SW sync chain and old-SW reg, and swapReq are all 0; lastGrant = 2, so channel 1 wins the first tie.
- Edge detect: iWEn is registered once (weN_d); edge = iWEn & ~weN_d.
  - On an edge, iAddrN/iDataN are captured into holdN and pendN <= 1 at that clock.
  - A level held high produces exactly one request.
- Overflow: on an edge while pendN=1 and pendN is not being cleared that cycle:
  - the new word is dropped (holdN keeps the old word);
  - oOvf[N] <= 1.
- Edge in the same cycle pendN clears: accepted and re-set; this is not an overflow.
- FSM states: IDLE, WRITE.
  - IDLE -> WRITE when any pend=1 and no swap is executing this cycle.
  - Grant: if only one channel is pending, it is granted. If both are pending, grant the channel that is not lastGrant.
  - On entry: oWE <= 1, oAddr <= {oPage, holdG.addr}, oData <= holdG.data, lastGrant <= G, cycle counter <= 1.
  - WRITE: the counter increments each cycle. When counter == WR_CYC: oWE <= 0, pendG <= 0, go to IDLE.
  - oAddr/oData stay stable for the whole WRITE.
  - oBusy mirrors state == WRITE.
- Latency: an edge sampled at clock k sets pend at k. With the arbiter idle, oWE is high from k+1 through k+WR_CYC, and the next grant can start at k+WR_CYC+2.
- Worst case: both channels edge in the same cycle. Both are served back-to-back with one IDLE cycle between them.
- Page control:
  - iSW passes through a 2-FF synchronizer. sync != oldSW sets swapReq; oldSW updates every cycle.
  - Swap executes in a cycle with state == IDLE, pend1 == pend2 == 0 and swapReq == 1. It does: oPage <= ~oPage, oSwap <= 1 for one cycle, swapReq <= 0, oOvf <= 0.
  - Pending words captured before the swap drain to the old page.
  - Edges arriving during the drain are also written to the old page.
  - A second SW toggle while swapReq=1 is absorbed, giving one swap only.
  - A swap and a new edge in the same cycle: the swap executes; the captured word goes to the new page.
- Width rules: oAddr = {oPage, AW-bit addr}, with no arithmetic on the address. The WR_CYC counter is 4 bits.
- Reset mid-WRITE: oWE drops immediately and asynchronously; the pending word is lost.

Decomposition:
- Shared package orb_pkg holds:
  - ORB_AW=11, ORB_DW=12;
  - FSM state encoding (ST_IDLE=0, ST_WRITE=1);
  - channel index constants (CH1=0, CH2=1).
- One natural sub-module, orb_req_capture: edge detect, hold register, pend flag and overflow for one channel. It is instantiated twice, with a clear input from the arbiter.
- Arbiter FSM and page sequencer stay in the top.

Test Plan:
- Single request: reset, iWE1 rising with iAddr1=0x020, iData1=0x5A8 -> oWE high 2 cycles starting 1 clock after the capture, oAddr=0x020, oData=0x5A8, oPage=0; no second write while iWE1 stays high.
- Simultaneous requests: iWE1 and iWE2 rise together with addresses 0x004 and 0x005 -> channel 1 written first, then after one idle cycle channel 2. A repeat of the tie grants channel 2 first.
- Overflow: hold iWE2 pending (iWE1 busy in WRITE), pulse iWE2 twice before the grant -> only the first word is written; oOvf=2'b10; the next swap clears oOvf to 0.
- Page swap with drain: pend1 set, toggle iSW -> channel 1 word written with oAddr[AW]=0, then oSwap pulses for 1 cycle, oPage=1. The following write has oAddr[11]=1, e.g. 0x800|addr.
- Double SW toggle within the drain window -> exactly one oSwap pulse, oPage flips once.
- Reset mid-WRITE (WR_CYC=4, assert rst at write cycle 2) -> oWE=0 asynchronously, all pend/oOvf/oPage=0. After release, a new iWE1 edge writes normally.
